// File: rtl/sweep_ctrl_pkg.sv
// Shared constants and the FSM state type for the sweep sequencer.
package sweep_ctrl_pkg;

   localparam int NBITS_COUNT = 4;
   localparam int NBITS_DWELL = 4;
   localparam int NBITS_SWEEP = 3;

   // Encoding is visible on state_o for LED/LCD debug, so keep it fixed.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DWELL = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/sweep_counter_ctrl_dwell_timer.sv
// Loadable down-counter that times the endpoint dwell; stops at zero.
module dwell_timer
   import sweep_ctrl_pkg::*;
#(
   parameter int W = NBITS_DWELL
) (
   input  logic         clk_2,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register, cleared by the shared asynchronous reset.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Ping-pong sweep sequencer driving a hex up/down counter datapath.
// Keeps a shadow of the counter value (pos) to detect endpoint arrival.
// All outputs are decoded from registers only (Moore).
module sweep_counter_ctrl
   import sweep_ctrl_pkg::*;
(
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   up_first,
   input  logic [NBITS_COUNT-1:0] start_val,
   input  logic [NBITS_COUNT-1:0] end_val,
   input  logic [NBITS_DWELL-1:0] dwell_cfg,
   input  logic [NBITS_SWEEP-1:0] sweeps_cfg,
   output logic                   load,
   output logic [NBITS_COUNT-1:0] data_in,
   output logic                   counter_on,
   output logic                   count_up,
   output logic [NBITS_COUNT-1:0] pos,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             state_o
);

   state_t                 state_q,     state_d;
   logic [NBITS_COUNT-1:0] pos_q,       pos_d;
   logic [NBITS_COUNT-1:0] start_val_q, start_val_d;
   logic [NBITS_COUNT-1:0] end_val_q,   end_val_d;
   logic [NBITS_COUNT-1:0] target_q,    target_d;
   logic [NBITS_DWELL-1:0] dwell_q,     dwell_d;
   logic [NBITS_SWEEP-1:0] sweeps_q,    sweeps_d;
   logic                   dir_q,       dir_d;
   logic                   tmr_load;
   logic                   tmr_dec;
   logic                   tmr_zero;

   dwell_timer #(.W(NBITS_DWELL)) u_dwell_timer (
      .clk_2    (clk_2),
      .reset    (reset),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (dwell_q),
      .zero     (tmr_zero)
   );

   // Next-state logic; stop aborts any active state and keeps pos.
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      start_val_d = start_val_q;
      end_val_d   = end_val_q;
      target_d    = target_q;
      dwell_d     = dwell_q;
      sweeps_d    = sweeps_q;
      dir_d       = dir_q;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;

      if (stop && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  start_val_d = start_val;
                  end_val_d   = end_val;
                  dwell_d     = dwell_cfg;
                  sweeps_d    = (sweeps_cfg == '0) ? NBITS_SWEEP'(1) : sweeps_cfg;
                  dir_d       = up_first;
                  target_d    = end_val;
                  state_d     = LOAD;
               end
            end
            LOAD: begin
               pos_d   = start_val_q;
               state_d = (start_val_q == end_val_q) ? DONE : RUN;
            end
            RUN: begin
               pos_d = dir_q ? (pos_q + NBITS_COUNT'(1)) : (pos_q - NBITS_COUNT'(1));
               if (pos_d == target_q) begin
                  tmr_load = 1'b1;
                  state_d  = DWELL;
               end
            end
            DWELL: begin
               if (tmr_zero) begin
                  sweeps_d = sweeps_q - NBITS_SWEEP'(1);
                  if (sweeps_d == '0) begin
                     state_d = DONE;
                  end else begin
                     dir_d    = ~dir_q;
                     target_d = (target_q == end_val_q) ? start_val_q : end_val_q;
                     state_d  = RUN;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath shadow registers, async active-high reset.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pos_q       <= '0;
         start_val_q <= '0;
         end_val_q   <= '0;
         target_q    <= '0;
         dwell_q     <= '0;
         sweeps_q    <= '0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         start_val_q <= start_val_d;
         end_val_q   <= end_val_d;
         target_q    <= target_d;
         dwell_q     <= dwell_d;
         sweeps_q    <= sweeps_d;
         dir_q       <= dir_d;
      end
   end

   // Moore output decode from registered state only.
   always_comb begin
      load       = (state_q == LOAD);
      counter_on = (state_q == RUN);
      count_up   = (state_q == RUN) && dir_q;
      busy       = (state_q == LOAD) || (state_q == RUN) || (state_q == DWELL);
      done       = (state_q == DONE);
      data_in    = start_val_q;
      pos        = pos_q;
      state_o    = state_q;
   end

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Directed, table-driven bench for sweep_counter_ctrl.
module tb_sweep_counter_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DWELL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clk_2;
  logic       reset;
  logic       start;
  logic       stop;
  logic       up_first;
  logic [3:0] start_val;
  logic [3:0] end_val;
  logic [3:0] dwell_cfg;
  logic [2:0] sweeps_cfg;
  logic       load;
  logic [3:0] data_in;
  logic       counter_on;
  logic       count_up;
  logic [3:0] pos;
  logic       busy;
  logic       done;
  logic [2:0] state_o;

  int checks;
  int errors;

  sweep_counter_ctrl dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .up_first   (up_first),
    .start_val  (start_val),
    .end_val    (end_val),
    .dwell_cfg  (dwell_cfg),
    .sweeps_cfg (sweeps_cfg),
    .load       (load),
    .data_in    (data_in),
    .counter_on (counter_on),
    .count_up   (count_up),
    .pos        (pos),
    .busy       (busy),
    .done       (done),
    .state_o    (state_o)
  );

  // clock / reset block
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       up_first;
    logic [3:0] sv;
    logic [3:0] ev;
    logic [3:0] dw;
    logic [2:0] sw;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  string      cfg_name;
  logic       cfg_up;
  logic [3:0] cfg_sv;
  logic [3:0] cfg_ev;
  logic [3:0] cfg_dw;
  logic [2:0] cfg_sw;

  // {state, pos, data_in, load, counter_on, count_up, busy, done}
  function automatic logic [15:0] pack_exp(logic [2:0] st, logic [3:0] p, logic [3:0] din,
                                           logic ld, logic on, logic up, logic dn);
    logic bz;
    bz = (st == S_LOAD) || (st == S_RUN) || (st == S_DWELL);
    return {st, p, din, ld, on, up, bz, dn};
  endfunction

  function automatic logic [15:0] actual_out();
    return {state_o, pos, data_in, load, counter_on, count_up, busy, done};
  endfunction

  task automatic set_cfg(string n, logic up, logic [3:0] sv, logic [3:0] ev,
                         logic [3:0] dw, logic [2:0] sw);
    cfg_name = n; cfg_up = up; cfg_sv = sv; cfg_ev = ev; cfg_dw = dw; cfg_sw = sw;
  endtask

  task automatic row(logic st_in, logic sp_in, logic [2:0] st, logic [3:0] p, logic [3:0] din,
                     logic ld, logic on, logic up, logic dn);
    vec_t v;
    v.name = cfg_name; v.start = st_in; v.stop = sp_in; v.up_first = cfg_up;
    v.sv = cfg_sv; v.ev = cfg_ev; v.dw = cfg_dw; v.sw = cfg_sw;
    v.exp = pack_exp(st, p, din, ld, on, up, dn);
    vecs.push_back(v);
  endtask

  // scoreboard compare
  task automatic check(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (state,pos,din,ld,on,up,busy,done)", n, act, exp);
    end
  endtask

  // driver: apply inputs away from the edge, then sample 1ns after it
  task automatic drive(logic st_in, logic sp_in, logic up, logic [3:0] sv, logic [3:0] ev,
                       logic [3:0] dw, logic [2:0] sw);
    @(negedge clk_2);
    start = st_in; stop = sp_in; up_first = up;
    start_val = sv; end_val = ev; dwell_cfg = dw; sweeps_cfg = sw;
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; up_first = 1'b0;
    start_val = 4'h0; end_val = 4'h0; dwell_cfg = 4'h0; sweeps_cfg = 3'd0;

    // basic sweep 2 -> 5, dwell 2 cycles, one sweep
    set_cfg("basic", 1'b1, 4'h2, 4'h5, 4'h1, 3'd1);
    row(1, 0, S_LOAD,  4'h0, 4'h2, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'h2, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h3, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h4, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_DWELL, 4'h5, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_DWELL, 4'h5, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_DONE,  4'h5, 4'h2, 0, 0, 0, 1);
    row(1, 0, S_DONE,  4'h5, 4'h2, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h5, 4'h2, 0, 0, 0, 0);

    // ping-pong 2 -> 5 -> 2
    set_cfg("pingpong", 1'b1, 4'h2, 4'h5, 4'h1, 3'd2);
    row(1, 0, S_LOAD,  4'h5, 4'h2, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'h2, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h3, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h4, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_DWELL, 4'h5, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_DWELL, 4'h5, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_RUN,   4'h5, 4'h2, 0, 1, 0, 0);
    row(1, 0, S_RUN,   4'h4, 4'h2, 0, 1, 0, 0);
    row(1, 0, S_RUN,   4'h3, 4'h2, 0, 1, 0, 0);
    row(1, 0, S_DWELL, 4'h2, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_DWELL, 4'h2, 4'h2, 0, 0, 0, 0);
    row(1, 0, S_DONE,  4'h2, 4'h2, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h2, 4'h2, 0, 0, 0, 0);

    // wrap-around E -> F -> 0 -> 1, zero dwell
    set_cfg("wrap", 1'b1, 4'hE, 4'h1, 4'h0, 3'd1);
    row(1, 0, S_LOAD,  4'h2, 4'hE, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'hE, 4'hE, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'hF, 4'hE, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h0, 4'hE, 0, 1, 1, 0);
    row(1, 0, S_DWELL, 4'h1, 4'hE, 0, 0, 0, 0);
    row(1, 0, S_DONE,  4'h1, 4'hE, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h1, 4'hE, 0, 0, 0, 0);

    // degenerate: equal endpoints skip RUN
    set_cfg("degenerate", 1'b1, 4'h7, 4'h7, 4'h3, 3'd1);
    row(1, 0, S_LOAD,  4'h1, 4'h7, 1, 0, 0, 0);
    row(1, 0, S_DONE,  4'h7, 4'h7, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h7, 4'h7, 0, 0, 0, 0);

    // sweeps_cfg = 0 acts as one sweep
    set_cfg("sweeps0", 1'b1, 4'h3, 4'h4, 4'h0, 3'd0);
    row(1, 0, S_LOAD,  4'h7, 4'h3, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'h3, 4'h3, 0, 1, 1, 0);
    row(1, 0, S_DWELL, 4'h4, 4'h3, 0, 0, 0, 0);
    row(1, 0, S_DONE,  4'h4, 4'h3, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h4, 4'h3, 0, 0, 0, 0);

    // down-first sweep 9 -> 7 with a 3-cycle dwell
    set_cfg("down", 1'b0, 4'h9, 4'h7, 4'h2, 3'd1);
    row(1, 0, S_LOAD,  4'h4, 4'h9, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'h9, 4'h9, 0, 1, 0, 0);
    row(1, 0, S_RUN,   4'h8, 4'h9, 0, 1, 0, 0);
    row(1, 0, S_DWELL, 4'h7, 4'h9, 0, 0, 0, 0);
    row(1, 0, S_DWELL, 4'h7, 4'h9, 0, 0, 0, 0);
    row(1, 0, S_DWELL, 4'h7, 4'h9, 0, 0, 0, 0);
    row(1, 0, S_DONE,  4'h7, 4'h9, 0, 0, 0, 1);
    row(0, 0, S_IDLE,  4'h7, 4'h9, 0, 0, 0, 0);

    // abort during RUN at pos 4, then start+stop in IDLE
    set_cfg("abort", 1'b1, 4'h2, 4'h9, 4'h0, 3'd1);
    row(1, 0, S_LOAD,  4'h7, 4'h2, 1, 0, 0, 0);
    row(1, 0, S_RUN,   4'h2, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h3, 4'h2, 0, 1, 1, 0);
    row(1, 0, S_RUN,   4'h4, 4'h2, 0, 1, 1, 0);
    row(1, 1, S_IDLE,  4'h4, 4'h2, 0, 0, 0, 0);
    row(1, 1, S_IDLE,  4'h4, 4'h2, 0, 0, 0, 0);
    row(0, 0, S_IDLE,  4'h4, 4'h2, 0, 0, 0, 0);

    // reset state
    @(posedge clk_2);
    #1;
    check("reset_state", actual_out(), 16'h0000);
    @(negedge clk_2);
    reset = 1'b0;
    @(posedge clk_2);
    #1;
    check("idle_after_reset", actual_out(), 16'h0000);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].up_first, vecs[i].sv, vecs[i].ev,
            vecs[i].dw, vecs[i].sw);
      check($sformatf("%s[%0d]", vecs[i].name, i), actual_out(), vecs[i].exp);
    end

    // async reset in the middle of DWELL, between clock edges
    drive(1, 0, 1'b1, 4'h2, 4'h5, 4'h3, 3'd1);
    check("ar_load", actual_out(), pack_exp(S_LOAD, 4'h4, 4'h2, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1'b1, 4'h2, 4'h5, 4'h3, 3'd1);
    end
    check("ar_run_last", actual_out(), pack_exp(S_RUN, 4'h4, 4'h2, 0, 1, 1, 0));
    drive(1, 0, 1'b1, 4'h2, 4'h5, 4'h3, 3'd1);
    check("ar_dwell", actual_out(), pack_exp(S_DWELL, 4'h5, 4'h2, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("ar_immediate", actual_out(), 16'h0000);
    @(posedge clk_2);
    #1;
    check("ar_held_start", actual_out(), 16'h0000);
    @(negedge clk_2);
    reset = 1'b0;
    @(posedge clk_2);
    #1;
    check("ar_relaunch", actual_out(), pack_exp(S_LOAD, 4'h0, 4'h2, 1, 0, 0, 0));
    drive(0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0);
    check("ar_run_cfg_ignored", actual_out(), pack_exp(S_RUN, 4'h2, 4'h2, 0, 1, 1, 0));
    drive(0, 1, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0);
    check("ar_stop", actual_out(), pack_exp(S_IDLE, 4'h2, 4'h2, 0, 0, 0, 0));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_counter_ctrl.md
Name: sweep_counter_ctrl

Overview:
Sequencer that drives the 4-bit hex up/down counter datapath (load / count_up / counter_on / data_in) to perform programmed ping-pong sweeps between two endpoints. It dwells at each endpoint for a programmed number of cycles and repeats for N sweeps. It keeps a shadow copy of the counter value so it knows when an endpoint is reached. It sits between SWI-derived configuration/command bits and the counter.

Parameters:
NBITS_COUNT, 4, width of counter value, endpoints and shadow position
NBITS_DWELL, 4, width of dwell-cycle configuration
NBITS_SWEEP, 3, width of sweep-count configuration

Ports:
clk_2  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
start  input  1  level; sampled in IDLE to launch a run; must drop to leave DONE
stop  input  1  level abort; highest priority after reset
up_first  input  1  direction of first sweep (1 = up, 0 = down)
start_val  input  NBITS_COUNT  first endpoint, loaded into counter
end_val  input  NBITS_COUNT  second endpoint
dwell_cfg  input  NBITS_DWELL  endpoint dwell; DWELL lasts dwell_cfg+1 cycles
sweeps_cfg  input  NBITS_SWEEP  number of endpoint-to-endpoint sweeps; 0 treated as 1
load  output  1  counter load strobe
data_in  output  NBITS_COUNT  counter load value
counter_on  output  1  counter enable
count_up  output  1  counter direction
pos  output  NBITS_COUNT  shadow counter value, equal to datapath count
busy  output  1  high in LOAD, RUN, DWELL
done  output  1  high in DONE
state_o  output  3  encoded FSM state, for LED/LCD debug

Behaviour:
- Reset (async): state=IDLE, pos=0, latched config=0, dir=0, dwell/sweep counters=0. All outputs 0.
- Outputs are a Moore decode of registered state and registers; no input-to-output combinational paths.
- IDLE: load=0, counter_on=0. If start=1 and stop=0 at an edge: latch start_val, end_val, dwell_cfg, sweeps_cfg (0->1); set dir=up_first and target=end_val; go to LOAD.
- LOAD (exactly 1 cycle): load=1, data_in=latched start_val. At the edge: pos<=start_val. If start_val==end_val go to DONE (no RUN); otherwise go to RUN.
- RUN: counter_on=1, count_up=dir. Each edge: pos<=pos±1, modulo 2^NBITS_COUNT (F+1=0, 0-1=F). If the next pos equals target, go to DWELL and load dwell_cnt=dwell_cfg.
- DWELL: counter_on=0, load=0. Each edge: if dwell_cnt≠0, decrement it. When dwell_cnt==0: decrement sweeps_left; if the result is 0 go to DONE; otherwise invert dir, swap target to the other endpoint, and go to RUN.
- DONE: done=1, counter held. Go to IDLE at the first edge with start=0, so one start level yields one run.
- stop=1 in any non-IDLE state: next state is IDLE, counter_on=0, pos retained. Configuration inputs are ignored outside IDLE.
- stop and start both high in IDLE: stay in IDLE.
- data_in=latched start_val in all states; it is only meaningful when load=1.
- Async reset during RUN or DWELL: immediate return to the reset condition. The datapath counter shares reset, so pos stays consistent with it.

Decomposition:
- Package sweep_ctrl_pkg: typedef enum logic[2:0] state_t {IDLE, LOAD, RUN, DWELL, DONE}; NBITS_COUNT, NBITS_DWELL, NBITS_SWEEP constants.
- One sub-module: dwell_timer, a loadable down-counter with zero flag used for DWELL.
- The FSM and shadow position stay in sweep_counter_ctrl.

Test Plan:
- Basic sweep: start_val=2, end_val=5, up_first=1, dwell_cfg=1, sweeps_cfg=1, start pulse. Required: IDLE -> LOAD (load=1, data_in=2) -> RUN for 3 cycles (pos 3, 4, 5, count_up=1) -> DWELL for 2 cycles (counter_on=0) -> DONE (done=1). IDLE again after start drops.
- Ping-pong: same as basic sweep with sweeps_cfg=2. Required: after DWELL, RUN with count_up=0 and pos 4, 3, 2, then 2-cycle DWELL, then DONE.
- Wrap-around: start_val=E, end_val=1, up_first=1, dwell_cfg=0, sweeps_cfg=1. Required: pos sequence E, F, 0, 1, then DWELL for 1 cycle, then DONE.
- Degenerate and zero config: start_val=end_val=7 gives LOAD followed directly by DONE with pos=7 and no RUN. sweeps_cfg=0 behaves exactly like sweeps_cfg=1.
- Abort: stop=1 during RUN at pos=4 (2->9 sweep). Required: IDLE next cycle, counter_on=0, pos=4 held, done=0. start+stop together in IDLE keeps IDLE.
- Async reset: assert reset mid-DWELL between clock edges. Required: outputs and pos are 0 immediately, state_o=IDLE. Held start relaunches a run only after reset deasserts.
